wb_burst_copy: RTL and testbench

//  Wishbone bus master that copies a block of 32-bit words from SRC to DST, for example

---
 rtl/wb_burst_copy.sv | 179 +++++++++++++++++
 tb/tb_wb_burst_copy.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_copy.sv
// Wishbone burst copy master: moves LEN words from SRC to DST by reading up to BURST words
// into a local buffer, then writing them back, one incrementing burst each way.
module wb_burst_copy #(
  parameter int unsigned BURST = 8,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      src_adr_i,
  input  logic [31:0]      dst_adr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      wb_adr_o,
  output logic [31:0]      wb_dat_o,
  input  logic [31:0]      wb_dat_i,
  output logic [3:0]       wb_sel_o,
  output logic             wb_we_o,
  output logic             wb_stb_o,
  output logic             wb_cyc_o,
  output logic [2:0]       wb_cti_o,
  output logic [1:0]       wb_bte_o,
  input  logic             wb_ack_i,
  input  logic             wb_err_i
);

  localparam int unsigned CntW = $clog2(BURST) + 1;
  localparam int unsigned IdxW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [2:0] {StIdle, StRd, StGap, StWr, StFin} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_rem;
  logic [CntW-1:0]  r_beat;
  logic             r_gap_wr;
  logic             r_err;
  logic [31:0]      r_buf [BURST];

  logic [CntW-1:0]  w_n;
  logic             w_last;
  logic             w_active;
  logic             w_ack;
  logic             w_fail;
  logic [LEN_W-1:0] w_rem_next;
  logic [31:0]      w_step;
  logic [31:0]      w_offs;

  // Burst size only depends on r_rem, which is constant across a RD/GAP/WR pair.
  always_comb begin
    if (r_rem >= LEN_W'(BURST)) begin
      w_n = CntW'(BURST);
    end else begin
      w_n = r_rem[CntW-1:0];
    end
  end

  assign w_last     = (r_beat == w_n - CntW'(1));
  assign w_active   = (r_state == StRd) || (r_state == StWr);
  assign w_fail     = w_active && wb_err_i;
  assign w_ack      = w_active && wb_ack_i && !wb_err_i;
  assign w_rem_next = r_rem - LEN_W'(w_n);
  assign w_step     = 32'(w_n) << 2;
  assign w_offs     = 32'(r_beat) << 2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (start_i) begin
          w_state_next = (len_i == '0) ? StFin : StRd;
        end
      end
      StRd: begin
        if (w_fail) begin
          w_state_next = StFin;
        end else if (w_ack && w_last) begin
          w_state_next = StGap;
        end
      end
      StGap: w_state_next = r_gap_wr ? StWr : StRd;
      StWr: begin
        if (w_fail) begin
          w_state_next = StFin;
        end else if (w_ack && w_last) begin
          w_state_next = (w_rem_next != '0) ? StGap : StFin;
        end
      end
      StFin:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_src    <= 32'h0;
      r_dst    <= 32'h0;
      r_rem    <= '0;
      r_beat   <= '0;
      r_gap_wr <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start_i) begin
            r_src    <= src_adr_i & 32'hFFFF_FFFC;
            r_dst    <= dst_adr_i & 32'hFFFF_FFFC;
            r_rem    <= len_i;
            r_beat   <= '0;
            r_gap_wr <= 1'b0;
            r_err    <= 1'b0;
          end
        end
        StRd, StWr: begin
          if (w_fail) begin
            r_err <= 1'b1;
          end else if (w_ack) begin
            if (w_last) begin
              r_beat   <= '0;
              r_gap_wr <= (r_state == StRd);
              if (r_state == StWr) begin
                r_src <= r_src + w_step;
                r_dst <= r_dst + w_step;
                r_rem <= w_rem_next;
              end
            end else begin
              r_beat <= r_beat + CntW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk_i) begin
    if ((r_state == StRd) && w_ack) begin
      r_buf[r_beat[IdxW-1:0]] <= wb_dat_i;
    end
  end

  always_comb begin
    wb_stb_o = w_active;
    wb_cyc_o = w_active;
    wb_we_o  = (r_state == StWr);
    wb_sel_o = w_active ? 4'hF : 4'h0;
    wb_adr_o = 32'h0;
    wb_dat_o = 32'h0;
    wb_cti_o = 3'b000;
    if (w_active) begin
      wb_adr_o = ((r_state == StWr) ? r_dst : r_src) + w_offs;
      if (w_n != CntW'(1)) begin
        wb_cti_o = w_last ? 3'b111 : 3'b010;
      end
    end
    if (r_state == StWr) begin
      wb_dat_o = r_buf[r_beat[IdxW-1:0]];
    end
  end

  assign wb_bte_o = 2'b00;
  assign busy_o   = (r_state != StIdle) && (r_state != StFin);
  assign done_o   = (r_state == StFin);
  assign err_o    = r_err;

endmodule

// File: tb/tb_wb_burst_copy.sv
// Directed and randomized copies against a Wishbone memory slave with optional wait states
// and error injection; bus traffic is compared with a burst-level reference model.
module tb_wb_burst_copy;

  localparam int BURST = 8;
  localparam int LEN_W = 16;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [2:0]  cti;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic [31:0]       src_adr_i = 32'h0;
  logic [31:0]       dst_adr_i = 32'h0;
  logic [LEN_W-1:0]  len_i = '0;
  logic              busy_o, done_o, err_o;
  logic [31:0]       wb_adr_o, wb_dat_o;
  logic [31:0]       wb_dat_i = 32'h0;
  logic [3:0]        wb_sel_o;
  logic              wb_we_o, wb_stb_o, wb_cyc_o;
  logic [2:0]        wb_cti_o;
  logic [1:0]        wb_bte_o;
  logic              wb_ack_i = 1'b0;
  logic              wb_err_i = 1'b0;

  wb_burst_copy #(.BURST(BURST), .LEN_W(LEN_W)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .src_adr_i(src_adr_i),
    .dst_adr_i(dst_adr_i),
    .len_i    (len_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_stb_o (wb_stb_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_cti_o (wb_cti_o),
    .wb_bte_o (wb_bte_o),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] srcw [$];
  beat_t       trace [$];
  beat_t       exp_q [$];
  int          exp_bursts;
  int          exp_err;

  int          wait_mode = 0;
  int          err_at = -1;
  int          rd_beats = 0;
  int          done_cnt = 0;
  int          burst_cnt = 0;
  int          waits_left = -1;
  bit          err_pending = 1'b0;
  logic        prev_cyc = 1'b0;
  logic [31:0] snap_adr, snap_dat;
  logic [2:0]  snap_cti;
  logic        snap_we;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdmem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [2:0] cti_of(input int n, input int k);
    if (n == 1) return 3'b000;
    return (k == n - 1) ? 3'b111 : 3'b010;
  endfunction

  // Reference: chunk the copy into min(BURST, remaining) pieces, read chunk then write chunk.
  task automatic build_model(input logic [31:0] sa, input logic [31:0] da, input int len,
                             input int errb);
    int rem, off, rd, n;
    logic [31:0] s, d;
    exp_q.delete();
    exp_bursts = 0;
    exp_err = 0;
    rem = len; off = 0; rd = 0; s = sa; d = da;
    while (rem > 0) begin
      n = (rem < BURST) ? rem : BURST;
      exp_bursts++;
      for (int k = 0; k < n; k++) begin
        if (rd == errb) begin
          exp_err = 1;
          return;
        end
        exp_q.push_back('{1'b0, s + 32'(4 * k), srcw[off + k], cti_of(n, k)});
        rd++;
      end
      exp_bursts++;
      for (int k = 0; k < n; k++) begin
        exp_q.push_back('{1'b1, d + 32'(4 * k), srcw[off + k], cti_of(n, k)});
      end
      s = s + 32'(4 * n);
      d = d + 32'(4 * n);
      rem = rem - n;
      off = off + n;
    end
  endtask

  // Memory slave: decides ack/err at the negedge so it is stable across the next posedge.
  always @(negedge clk) begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = $urandom;
    if (err_pending) begin
      check("cyc_after_err", {31'b0, wb_cyc_o}, 32'd0);
      check("stb_after_err", {31'b0, wb_stb_o}, 32'd0);
      err_pending = 1'b0;
    end
    if (done_o) done_cnt++;
    if (wb_cyc_o && !prev_cyc) burst_cnt++;
    prev_cyc = wb_cyc_o;
    if (wb_stb_o && !rst_i) begin
      if (waits_left < 0) begin
        snap_adr = wb_adr_o;
        snap_dat = wb_dat_o;
        snap_cti = wb_cti_o;
        snap_we  = wb_we_o;
        waits_left = (wait_mode != 0 && $urandom_range(0, 1) == 1) ? 3 : 0;
      end else begin
        check("hold_adr", wb_adr_o, snap_adr);
        check("hold_dat", wb_dat_o, snap_dat);
        check("hold_cti", {29'b0, wb_cti_o}, {29'b0, snap_cti});
        check("hold_we", {31'b0, wb_we_o}, {31'b0, snap_we});
      end
      if (waits_left == 0) begin
        check("sel", {28'b0, wb_sel_o}, 32'hF);
        if (!wb_we_o && rd_beats == err_at) begin
          wb_err_i = 1'b1;
          err_pending = 1'b1;
        end else if (!wb_we_o) begin
          wb_dat_i = rdmem(wb_adr_o);
          wb_ack_i = 1'b1;
          trace.push_back('{1'b0, wb_adr_o, wb_dat_i, wb_cti_o});
        end else begin
          mem[wb_adr_o] = wb_dat_o;
          wb_ack_i = 1'b1;
          trace.push_back('{1'b1, wb_adr_o, wb_dat_o, wb_cti_o});
        end
        if (!wb_we_o) rd_beats++;
        waits_left = -1;
      end else begin
        waits_left--;
      end
    end else begin
      waits_left = -1;
    end
  end

  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input int wmode, input int errb, input bit poke, input bit finpoke);
    logic [31:0] sa, da, w;
    int cnt;
    sa = src & 32'hFFFF_FFFC;
    da = dst & 32'hFFFF_FFFC;
    mem.delete();
    trace.delete();
    srcw.delete();
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      srcw.push_back(w);
      mem[sa + 32'(4 * i)] = w;
    end
    build_model(sa, da, len, errb);
    wait_mode = wmode;
    err_at = errb;
    rd_beats = 0;
    done_cnt = 0;
    burst_cnt = 0;
    @(negedge clk);
    src_adr_i = src;
    dst_adr_i = dst;
    len_i = 16'(len);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("err_cleared_by_start", {31'b0, err_o}, 32'd0);
    check("cyc_cycle1", {31'b0, wb_cyc_o}, (len != 0) ? 32'd1 : 32'd0);
    cnt = 0;
    while (busy_o === 1'b1 && cnt < 4000) begin
      if (poke && cnt == 4) begin
        start_i = 1'b1;
        src_adr_i = ~src;
        dst_adr_i = ~dst;
        len_i = 16'd3;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    start_i = 1'b0;
    check("timeout", (cnt < 4000) ? 32'd1 : 32'd0, 32'd1);
    check("done_when_busy_falls", {31'b0, done_o}, 32'd1);
    if (finpoke) begin
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      check("fin_start_busy", {31'b0, busy_o}, 32'd0);
      check("fin_start_cyc", {31'b0, wb_cyc_o}, 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    check("done_count", done_cnt, 32'd1);
    check("burst_count", burst_cnt, exp_bursts);
    check("err_o", {31'b0, err_o}, exp_err);
    check("beats", trace.size(), exp_q.size());
    for (int i = 0; i < trace.size() && i < exp_q.size(); i++) begin
      check($sformatf("b%0d.we", i), {31'b0, trace[i].we}, {31'b0, exp_q[i].we});
      check($sformatf("b%0d.adr", i), trace[i].adr, exp_q[i].adr);
      check($sformatf("b%0d.dat", i), trace[i].dat, exp_q[i].dat);
      check($sformatf("b%0d.cti", i), {29'b0, trace[i].cti}, {29'b0, exp_q[i].cti});
    end
    if (exp_err == 0) begin
      for (int i = 0; i < len; i++) begin
        check($sformatf("dst%0d", i), rdmem(da + 32'(4 * i)), srcw[i]);
      end
    end
  endtask

  initial begin
    logic [31:0] rs;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_err", {31'b0, err_o}, 32'd0);
    check("rst_stb", {31'b0, wb_stb_o}, 32'd0);
    check("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
    check("rst_we", {31'b0, wb_we_o}, 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_sel", {28'b0, wb_sel_o}, 32'd0);
    check("rst_cti", {29'b0, wb_cti_o}, 32'd0);
    check("rst_bte", {30'b0, wb_bte_o}, 32'd0);
    rst_i = 1'b0;

    run_copy(32'h000F_F000, 32'h0000_1000, 20, 0, -1, 1'b0, 1'b0);
    run_copy(32'h000F_F000, 32'h0000_1000, 1, 0, -1, 1'b0, 1'b0);
    run_copy(32'h0002_0000, 32'h0004_0000, 13, 1, -1, 1'b0, 1'b0);
    run_copy(32'h000F_F000, 32'h0000_1000, 20, 0, 3, 1'b0, 1'b0);
    run_copy(32'h000F_F100, 32'h0000_2000, 9, 0, -1, 1'b0, 1'b0);
    run_copy(32'h000F_F000, 32'h0000_1000, 0, 0, -1, 1'b0, 1'b0);
    run_copy(32'h0001_0000, 32'h0003_0000, 12, 1, -1, 1'b1, 1'b0);
    run_copy(32'hFFFF_FFFB, 32'h0000_3002, 5, 0, -1, 1'b0, 1'b1);
    run_copy(32'h0005_0000, 32'h0006_0000, 16, 1, 10, 1'b0, 1'b0);

    for (int t = 0; t < 4; t++) begin
      rs = $urandom & 32'h0FFF_FFFF;
      run_copy(rs, rs ^ 32'h8000_0000, $urandom_range(1, 40), $urandom_range(0, 1), -1,
               1'b0, 1'b0);
    end

    // Reset in the middle of a read burst
    mem.delete();
    wait_mode = 0;
    err_at = -1;
    @(negedge clk);
    src_adr_i = 32'h000F_F000;
    dst_adr_i = 32'h0000_1000;
    len_i = 16'd20;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_burst_stb", {31'b0, wb_stb_o}, 32'd1);
    done_cnt = 0;
    rst_i = 1'b1;
    @(negedge clk);
    check("rst_mid_stb", {31'b0, wb_stb_o}, 32'd0);
    check("rst_mid_cyc", {31'b0, wb_cyc_o}, 32'd0);
    check("rst_mid_busy", {31'b0, busy_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_no_done", done_cnt, 32'd0);
    check("rst_mid_idle_cyc", {31'b0, wb_cyc_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
